// File: rtl/fbw_stream_loader_pkg.sv
// Shared frame-buffer write-side definitions: default panel geometry, derived widths, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fbw_stream_loader_pkg;

    // Default panel geometry; must stay powers of two so row/col counters wrap naturally.
    localparam int DEF_N_ROWS   = 64;
    localparam int DEF_N_COLS   = 64;
    localparam int PIX_BITDEPTH = 16;

    localparam int LOG_N_ROWS = $clog2(DEF_N_ROWS);
    localparam int LOG_N_COLS = $clog2(DEF_N_COLS);

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_SYNC       = 3'd0,
        ST_WAIT_ROW   = 3'd1,
        ST_LOAD       = 3'd2,
        ST_FLUSH      = 3'd3,
        ST_STORE      = 3'd4,
        ST_FRAME_WAIT = 3'd5
    } state_e;

    // Which byte of the current pixel is expected next.
    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

    // A pixel as presented on the frame-buffer write port: {hi, lo}.
    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } pixel_t;

endpackage

// File: rtl/fbw_stream_loader.sv
// Packs a byte stream (lo byte first) into 16-bit pixels and writes them row by row into the hub75 frame buffer.
// Latency: pixel write one cycle after its hi byte is accepted; row store/swap two cycles after the last hi byte.
// Backpressure: in_ready low while flushing/storing a row, waiting for fbw_row_rdy, or waiting for frame_rdy.
module fbw_stream_loader
    import fbw_stream_loader_pkg::*;
#(
    parameter int N_ROWS   = DEF_N_ROWS,
    parameter int N_COLS   = DEF_N_COLS,
    parameter int BITDEPTH = PIX_BITDEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic                      in_ready,
    output logic [$clog2(N_ROWS)-1:0] fbw_row_addr,
    output logic                      fbw_row_store,
    input  logic                      fbw_row_rdy,
    output logic                      fbw_row_swap,
    output logic [BITDEPTH-1:0]       fbw_data,
    output logic [$clog2(N_COLS)-1:0] fbw_col_addr,
    output logic                      fbw_wren,
    output logic                      frame_swap,
    input  logic                      frame_rdy,
    output logic                      frame_done,
    output logic                      stat_resync
);

    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);

    state_e         state_q,  state_d;
    logic [RW-1:0]  row_q,    row_d;
    logic [CW-1:0]  col_q,    col_d;
    half_e          half_q,   half_d;
    logic [7:0]     lo_q,     lo_d;
    logic           wren_q,   wren_d;
    pixel_t         wdat_q,   wdat_d;
    logic [CW-1:0]  wcol_q,   wcol_d;
    logic           resync_q, resync_d;
    logic           row_store;
    logic           frm_swap;
    logic           at_frame_start;

    // A sof byte is legitimate only where the lo byte of row 0 / col 0 is expected.
    assign at_frame_start = (row_q == '0) && (col_q == '0) && (half_q == HALF_LO);

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        half_d    = half_q;
        lo_d      = lo_q;
        wren_d    = 1'b0;
        wdat_d    = wdat_q;
        wcol_d    = wcol_q;
        resync_d  = 1'b0;
        in_ready  = 1'b0;
        row_store = 1'b0;
        frm_swap  = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // Bytes are swallowed until a sof byte starts a frame.
                in_ready = fbw_row_rdy;
                if (in_valid && fbw_row_rdy && in_sof) begin
                    lo_d    = in_data;
                    row_d   = '0;
                    col_d   = '0;
                    half_d  = HALF_HI;
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT_ROW: begin
                if (fbw_row_rdy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sof && !at_frame_start) begin
                        // Out-of-place sof: drop the partial row and restart the frame on this byte.
                        resync_d = 1'b1;
                        row_d    = '0;
                        col_d    = '0;
                        lo_d     = in_data;
                        half_d   = HALF_HI;
                    end else if (half_q == HALF_LO) begin
                        lo_d   = in_data;
                        half_d = HALF_HI;
                    end else begin
                        wren_d    = 1'b1;
                        wdat_d.hi = in_data;
                        wdat_d.lo = lo_q;
                        wcol_d    = col_q;
                        col_d     = col_q + 1'b1;
                        half_d    = HALF_LO;
                        if (&col_q) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // The last pixel's registered write is on the port this cycle.
                state_d = ST_STORE;
            end
            ST_STORE: begin
                row_store = 1'b1;
                if (&row_q) begin
                    state_d = ST_FRAME_WAIT;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_WAIT_ROW;
                end
            end
            ST_FRAME_WAIT: begin
                if (frame_rdy) begin
                    frm_swap = 1'b1;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = ST_WAIT_ROW;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State, counters and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            row_q    <= '0;
            col_q    <= '0;
            half_q   <= HALF_LO;
            lo_q     <= '0;
            wren_q   <= 1'b0;
            wdat_q   <= '0;
            wcol_q   <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            half_q   <= half_d;
            lo_q     <= lo_d;
            wren_q   <= wren_d;
            wdat_q   <= wdat_d;
            wcol_q   <= wcol_d;
            resync_q <= resync_d;
        end
    end

    assign fbw_row_addr  = row_q;
    assign fbw_row_store = row_store;
    assign fbw_row_swap  = row_store;
    assign fbw_data      = wdat_q;
    assign fbw_col_addr  = wcol_q;
    assign fbw_wren      = wren_q;
    assign frame_swap    = frm_swap;
    assign frame_done    = frm_swap;
    assign stat_resync   = resync_q;

endmodule

// File: tb/tb_fbw_stream_loader.sv
// Scoreboard bench: stimulus pushes expected writes/stores/frames/resyncs, a negedge monitor pops and compares.
// Latency: n/a.
// Backpressure: byte driver holds each byte until in_ready, bounded by a timeout.
module tb_fbw_stream_loader;
    import fbw_stream_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [5:0]  fbw_row_addr;
    logic        fbw_row_store;
    logic        fbw_row_rdy = 1'b1;
    logic        fbw_row_swap;
    logic [15:0] fbw_data;
    logic [5:0]  fbw_col_addr;
    logic        fbw_wren;
    logic        frame_swap;
    logic        frame_rdy = 1'b0;
    logic        frame_done;
    logic        stat_resync;

    fbw_stream_loader #(.N_ROWS(64), .N_COLS(64), .BITDEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
        .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr),
        .fbw_wren(fbw_wren), .frame_swap(frame_swap), .frame_rdy(frame_rdy),
        .frame_done(frame_done), .stat_resync(stat_resync)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_store[$];
    int  exp_resync = 0;
    int  exp_frames = 0;
    int  errors = 0;
    int  checks = 0;
    wr_t mon_w;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic int pix(input int r, input int c);
        return ((r * 64 + c) * 40503 + 17) & 16'hFFFF;
    endfunction

    // Hold one byte until accepted; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                fail_timeout("accept");
                in_valid = 1'b0;
                in_sof   = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_pixel(input int r, input int c, input int d, input logic sof);
        wr_t w;
        w.row  = r;
        w.col  = c;
        w.data = d;
        send_byte(d[7:0], sof);
        exp_wr.push_back(w);
        send_byte(d[15:8], 1'b0);
    endtask

    // Send pixels [c0, c1] of row r; a completed row expects a store.
    task automatic send_cols(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            send_pixel(r, c, pix(r, c), 1'b0);
        end
        if (c1 == 63) exp_store.push_back(r);
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (fbw_wren) begin
            check("write_expected", int'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                mon_w = exp_wr.pop_front();
                check("wr_data", fbw_data, mon_w.data);
                check("wr_col", fbw_col_addr, mon_w.col);
                check("wr_row", fbw_row_addr, mon_w.row);
            end
        end
        if (fbw_row_store || fbw_row_swap) begin
            check("store_swap_pair", fbw_row_swap, fbw_row_store);
            check("store_expected", int'(exp_store.size() > 0), 1);
            if (exp_store.size() > 0) check("store_row", fbw_row_addr, exp_store.pop_front());
        end
        if (frame_swap || frame_done) begin
            check("frame_done_pair", frame_done, frame_swap);
            check("frame_rdy_at_swap", frame_rdy, 1);
            check("frame_expected", int'(exp_frames > 0), 1);
            if (exp_frames > 0) exp_frames--;
        end
        if (stat_resync) begin
            check("resync_expected", int'(exp_resync > 0), 1);
            if (exp_resync > 0) exp_resync--;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wren"}, fbw_wren, 0);
        check({tag, "_row_store"}, fbw_row_store, 0);
        check({tag, "_row_swap"}, fbw_row_swap, 0);
        check({tag, "_frame_swap"}, frame_swap, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_resync"}, stat_resync, 0);
        check({tag, "_row_addr"}, fbw_row_addr, 0);
        check({tag, "_col_addr"}, fbw_col_addr, 0);
        check({tag, "_data"}, fbw_data, 0);
    endtask

    initial begin
        int n;
        // Reset state.
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First pixel: 0x34 (sof) then 0x12 -> 0x1234 at row 0 col 0, one cycle after acceptance.
        send_pixel(0, 0, 16'h1234, 1'b1);
        check("first_wren_latency", fbw_wren, 1);
        check("first_data", fbw_data, 16'h1234);
        check("first_col", fbw_col_addr, 0);
        check("first_row", fbw_row_addr, 0);

        // Rest of row 0, then withhold fbw_row_rdy.
        send_cols(0, 1, 63);
        fbw_row_rdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rowrdy_low_in_ready", in_ready, 0);
            if (i >= 1) check("rowrdy_low_no_write", fbw_wren, 0);
        end
        @(posedge clk);
        #1;
        fbw_row_rdy = 1'b1;

        // Remaining rows of the frame, frame_rdy held low.
        for (int r = 1; r < 64; r++) send_cols(r, 0, 63);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("frame_swap_held", frame_swap, 0);
            check("frame_wait_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        exp_frames = 1;
        frame_rdy  = 1'b1;
        n = 0;
        while (exp_frames > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_frames > 0) fail_timeout("frame_swap");
        frame_rdy = 1'b0;

        // Second frame without sof; sof in row 3 col 10 forces a resync into row 0.
        for (int r = 0; r < 3; r++) send_cols(r, 0, 63);
        send_cols(3, 0, 9);
        exp_resync = 1;
        send_pixel(0, 0, 16'hBEEF, 1'b1);
        send_cols(0, 1, 63);

        // Partial row 1, then asynchronous reset mid-row.
        send_cols(1, 0, 4);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrow_reset");
        check("pending_writes_at_reset", exp_wr.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Non-sof bytes after reset are discarded; the sof byte restarts row 0 col 0.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_pixel(0, 0, 16'hABCD, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_stores", exp_store.size(), 0);
        check("leftover_resync", exp_resync, 0);
        check("leftover_frames", exp_frames, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
